// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider:
// FSM state encoding and the default operand width.
package seq_divider_pkg;

  localparam int DIV_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/seq_divider_cla.sv
// Carry-lookahead adder built from 4-bit lookahead groups with rippled group carries.
// Used by the divider for the trial subtraction (B = ~divisor, cin = 1).
module claAdder #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  localparam int NG = W / 4;

  logic [W-1:0] g_s;
  logic [W-1:0] p_s;
  logic [W-1:0] c_s;
  logic [NG:0]  gc_s;

  assign g_s = a & b;
  assign p_s = a ^ b;

  // Per-group lookahead carries; the group carry-out feeds the next group.
  always_comb begin
    c_s     = {W{1'b0}};
    gc_s    = {(NG+1){1'b0}};
    gc_s[0] = cin;
    for (int k = 0; k < NG; k++) begin
      c_s[4*k]   = gc_s[k];
      c_s[4*k+1] = g_s[4*k] | (p_s[4*k] & gc_s[k]);
      c_s[4*k+2] = g_s[4*k+1] | (p_s[4*k+1] & g_s[4*k])
                 | (p_s[4*k+1] & p_s[4*k] & gc_s[k]);
      c_s[4*k+3] = g_s[4*k+2] | (p_s[4*k+2] & g_s[4*k+1])
                 | (p_s[4*k+2] & p_s[4*k+1] & g_s[4*k])
                 | (p_s[4*k+2] & p_s[4*k+1] & p_s[4*k] & gc_s[k]);
      gc_s[k+1]  = g_s[4*k+3] | (p_s[4*k+3] & g_s[4*k+2])
                 | (p_s[4*k+3] & p_s[4*k+2] & g_s[4*k+1])
                 | (p_s[4*k+3] & p_s[4*k+2] & p_s[4*k+1] & g_s[4*k])
                 | (p_s[4*k+3] & p_s[4*k+2] & p_s[4*k+1] & p_s[4*k] & gc_s[k]);
    end
  end

  assign sum  = p_s ^ c_s;
  assign cout = gc_s[NG];

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Results, done and div_by_zero are registered on the edge that leaves FIN.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state_r;
  state_t           state_nxt_s;
  logic             accept_s;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] div_r;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] rem_r;
  logic             dz_r;
  logic [WIDTH:0]   rem_sh_s;
  logic [WIDTH-1:0] trial_s;
  logic             cout_s;
  logic             keep_s;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] quotient_r;
  logic [WIDTH-1:0] remainder_r;
  logic             dz_out_r;

  // The shifted partial remainder is WIDTH+1 bits; its top bit alone guarantees no borrow.
  assign rem_sh_s = {rem_r, q_r[WIDTH-1]};
  assign keep_s   = rem_sh_s[WIDTH] | cout_s;

  claAdder #(.W(WIDTH)) u_cla (
    .a    (rem_sh_s[WIDTH-1:0]),
    .b    (~div_r),
    .cin  (1'b1),
    .sum  (trial_s),
    .cout (cout_s)
  );

  // Next-state decode and start acceptance.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    case (state_r)
      IDLE, FIN: begin
        if (start) begin
          accept_s = 1'b1;
          if (divisor == {WIDTH{1'b0}}) begin
            state_nxt_s = FIN;
          end else begin
            state_nxt_s = RUN;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == CW'(1)) begin
          state_nxt_s = FIN;
        end else begin
          state_nxt_s = RUN;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // All divider state: FSM, working registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= {CW{1'b0}};
      div_r       <= {WIDTH{1'b0}};
      q_r         <= {WIDTH{1'b0}};
      rem_r       <= {WIDTH{1'b0}};
      dz_r        <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      quotient_r  <= {WIDTH{1'b0}};
      remainder_r <= {WIDTH{1'b0}};
      dz_out_r    <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s == RUN);
      done_r  <= (state_r == FIN);
      if (state_r == FIN) begin
        quotient_r  <= q_r;
        remainder_r <= rem_r;
        dz_out_r    <= dz_r;
      end
      if (accept_s) begin
        div_r <= divisor;
        cnt_r <= CW'(WIDTH);
        if (divisor == {WIDTH{1'b0}}) begin
          q_r   <= {WIDTH{1'b1}};
          rem_r <= dividend;
          dz_r  <= 1'b1;
        end else begin
          q_r   <= dividend;
          rem_r <= {WIDTH{1'b0}};
          dz_r  <= 1'b0;
        end
      end else if (state_r == RUN) begin
        cnt_r <= cnt_r - CW'(1);
        rem_r <= keep_s ? trial_s : rem_sh_s[WIDTH-1:0];
        q_r   <= {q_r[WIDTH-2:0], keep_s};
      end
    end
  end

  assign busy        = busy_r;
  assign done        = done_r;
  assign quotient    = quotient_r;
  assign remainder   = remainder_r;
  assign div_by_zero = dz_out_r;

endmodule

// File: tb/tb_seq_divider.sv
// Directed table-driven bench for seq_divider (WIDTH=16) plus hand-written
// sequences for ignored start, mid-division reset and back-to-back starts.
module tb_seq_divider;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;

  int total;
  int bad;

  typedef struct {
    logic [15:0] dd;
    logic [15:0] dv;
    logic [15:0] q;
    logic [15:0] r;
    logic        dz;
    int          lat;
    int          bcnt;
  } vec_t;

  vec_t vecs [9];

  seq_divider #(.WIDTH(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one edge, then wait (bounded) for done; samples #1 after each edge.
  task automatic do_div(input logic [15:0] a, input logic [15:0] b,
                        output int lat, output int bcnt);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    tick();
    start = 1'b0;
    lat   = 0;
    bcnt  = busy ? 1 : 0;
    while (!done && lat < 100) begin
      tick();
      lat++;
      if (busy) bcnt++;
    end
  endtask

  initial begin
    int lat;
    int bcnt;
    int seen;
    total    = 0;
    bad      = 0;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = 16'd0;
    divisor  = 16'd0;

    vecs[0] = '{16'd100,    16'd7,      16'd14,     16'd2,      1'b0, 17, 16};
    vecs[1] = '{16'hFFFF,   16'd1,      16'hFFFF,   16'd0,      1'b0, 17, 16};
    vecs[2] = '{16'd3,      16'd10,     16'd0,      16'd3,      1'b0, 17, 16};
    vecs[3] = '{16'd5,      16'd0,      16'hFFFF,   16'd5,      1'b1, 1,  0};
    vecs[4] = '{16'd0,      16'd5,      16'd0,      16'd0,      1'b0, 17, 16};
    vecs[5] = '{16'd1000,   16'd1000,   16'd1,      16'd0,      1'b0, 17, 16};
    vecs[6] = '{16'h8000,   16'd3,      16'h2AAA,   16'd2,      1'b0, 17, 16};
    vecs[7] = '{16'hFFFF,   16'hFFFF,   16'd1,      16'd0,      1'b0, 17, 16};
    vecs[8] = '{16'hFFFF,   16'h8000,   16'd1,      16'h7FFF,   1'b0, 17, 16};

    tick();
    tick();
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_quot", {16'd0, quotient}, 32'd0);
    check("reset_rem",  {16'd0, remainder}, 32'd0);
    check("reset_dz",   {31'd0, div_by_zero}, 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 9; i++) begin
      do_div(vecs[i].dd, vecs[i].dv, lat, bcnt);
      check($sformatf("v%0d_quot", i), {16'd0, quotient}, {16'd0, vecs[i].q});
      check($sformatf("v%0d_rem", i),  {16'd0, remainder}, {16'd0, vecs[i].r});
      check($sformatf("v%0d_dz", i),   {31'd0, div_by_zero}, {31'd0, vecs[i].dz});
      check($sformatf("v%0d_lat", i),  lat, vecs[i].lat);
      check($sformatf("v%0d_busy", i), bcnt, vecs[i].bcnt);
      tick();
      check($sformatf("v%0d_pulse", i), {31'd0, done}, 32'd0);
      check($sformatf("v%0d_hold", i), {16'd0, quotient}, {16'd0, vecs[i].q});
    end

    // Start while busy must be ignored.
    dividend = 16'h1234;
    divisor  = 16'h0056;
    start    = 1'b1;
    tick();
    start = 1'b0;
    lat   = 0;
    while (!done && lat < 100) begin
      tick();
      lat++;
      if (lat == 5) begin
        dividend = 16'd9;
        divisor  = 16'd3;
        start    = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    check("ign_quot", {16'd0, quotient}, 32'h0036);
    check("ign_rem",  {16'd0, remainder}, 32'h0010);
    check("ign_lat",  lat, 17);
    tick();

    // Reset in the middle of a division aborts it.
    dividend = 16'd100;
    divisor  = 16'd7;
    start    = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    rst = 1'b1;
    tick();
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_quot", {16'd0, quotient}, 32'd0);
    check("abort_rem",  {16'd0, remainder}, 32'd0);
    rst  = 1'b0;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (done) seen++;
    end
    check("abort_nodone", seen, 0);
    do_div(16'd100, 16'd7, lat, bcnt);
    check("after_quot", {16'd0, quotient}, 32'd14);
    check("after_rem",  {16'd0, remainder}, 32'd2);
    check("after_lat",  lat, 17);
    tick();

    // Start held high through FIN: back-to-back divisions.
    dividend = 16'd100;
    divisor  = 16'd7;
    start    = 1'b1;
    tick();
    dividend = 16'd3;
    divisor  = 16'd10;
    lat = 0;
    while (!done && lat < 100) begin
      tick();
      lat++;
    end
    check("b2b_lat1",  lat, 17);
    check("b2b_quot1", {16'd0, quotient}, 32'd14);
    check("b2b_rem1",  {16'd0, remainder}, 32'd2);
    check("b2b_busy",  {31'd0, busy}, 32'd1);
    tick();
    start = 1'b0;
    check("b2b_pulse1", {31'd0, done}, 32'd0);
    lat = 1;
    while (!done && lat < 100) begin
      tick();
      lat++;
    end
    check("b2b_lat2",  lat, 17);
    check("b2b_quot2", {16'd0, quotient}, 32'd0);
    check("b2b_rem2",  {16'd0, remainder}, 32'd3);
    tick();
    check("b2b_pulse2", {31'd0, done}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
